cordic_rot_sched: RTL and testbench

Round-robin scheduler that shares one pipelined CORDIC rotation core among `NUM_REQ` requesters, such as the Givens/orthogonalisation units of the FastICA datapath. It accepts one rotation request per cycle via valid/ready handshakes and registers the operands into the core. A fixed-latency tag pipeline tracks the owner of each in-flight operation, and each result is returned with its requester ID. It sits directly in front of the rotation core and owns that core's `enable_in` and operand ports.

---
 rtl/cordic_rot_sched_if.sv | 58 +++++
 rtl/cordic_rot_sched.sv | 148 ++++++++++++++
 tb/tb_cordic_rot_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_rot_sched_if.sv
// cordic_rot_sched_if
//   Groups every signal around the round-robin CORDIC scheduler except clk and nreset.
//   slave  : the scheduler's view.
//   master : the environment's view (requesters, rotation core and result sink).
//   Requester side : hold, req_valid/req_ready handshake, and packed per-requester operands.
//   Core side      : core_en and operands out; core_xo, core_yo and core_vld in.
//   Result side    : res_valid, res_id, res_x, res_y.
//   Status         : inflight, idle, err.
interface cordic_rot_sched_if #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ANGLE_WIDTH   = 16,
  parameter int CORDIC_STAGES = 16,
  parameter int CORE_LATENCY  = 18,
  parameter int ID_W          = $clog2(NUM_REQ),
  parameter int CNT_W         = $clog2(CORE_LATENCY + 2)
);
  logic                               hold;
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_mode;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_x;
  logic [NUM_REQ*DATA_WIDTH-1:0]      req_y;
  logic [NUM_REQ*ANGLE_WIDTH-1:0]     req_angle;
  logic [NUM_REQ*CORDIC_STAGES-1:0]   req_dir;
  logic [NUM_REQ*2-1:0]               req_quad;
  logic                               core_en;
  logic                               core_mode;
  logic [DATA_WIDTH-1:0]              core_x;
  logic [DATA_WIDTH-1:0]              core_y;
  logic [ANGLE_WIDTH-1:0]             core_angle;
  logic [CORDIC_STAGES-1:0]           core_dir;
  logic [1:0]                         core_quad;
  logic [DATA_WIDTH-1:0]              core_xo;
  logic [DATA_WIDTH-1:0]              core_yo;
  logic                               core_vld;
  logic                               res_valid;
  logic [ID_W-1:0]                    res_id;
  logic [DATA_WIDTH-1:0]              res_x;
  logic [DATA_WIDTH-1:0]              res_y;
  logic [CNT_W-1:0]                   inflight;
  logic                               idle;
  logic                               err;

  modport slave (
    input  hold, req_valid, req_mode, req_x, req_y, req_angle, req_dir, req_quad,
    input  core_xo, core_yo, core_vld,
    output req_ready, core_en, core_mode, core_x, core_y, core_angle, core_dir, core_quad,
    output res_valid, res_id, res_x, res_y, inflight, idle, err
  );

  modport master (
    output hold, req_valid, req_mode, req_x, req_y, req_angle, req_dir, req_quad,
    output core_xo, core_yo, core_vld,
    input  req_ready, core_en, core_mode, core_x, core_y, core_angle, core_dir, core_quad,
    input  res_valid, res_id, res_x, res_y, inflight, idle, err
  );
endinterface

// File: rtl/cordic_rot_sched.sv
// cordic_rot_sched
//   Shares one pipelined CORDIC rotation core among NUM_REQ requesters.
//   A combinational round-robin arbiter issues at most one grant per cycle.
//   The granted operands are registered onto the core inputs.
//   A CORE_LATENCY-deep tag pipeline returns each result with its owner's ID.
// Ports
//   clk    : rising-edge clock.
//   nreset : synchronous active-low reset. The same net resets the core.
//   bus    : cordic_rot_sched_if.slave. It carries the requester, core, result and status signals.
// The tag pipeline requires CORE_LATENCY >= 2.
module cordic_rot_sched #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int ANGLE_WIDTH   = 16,
  parameter int CORDIC_STAGES = 16,
  parameter int CORE_LATENCY  = 18,
  parameter int ID_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               nreset,
  cordic_rot_sched_if.slave  bus
);
  localparam int CNT_W = $clog2(CORE_LATENCY + 2);

  logic [ID_W-1:0]          r_ptr;
  logic                     r_core_en;
  logic [ID_W-1:0]          r_issue_id;
  logic                     r_core_mode;
  logic [DATA_WIDTH-1:0]    r_core_x;
  logic [DATA_WIDTH-1:0]    r_core_y;
  logic [ANGLE_WIDTH-1:0]   r_core_angle;
  logic [CORDIC_STAGES-1:0] r_core_dir;
  logic [1:0]               r_core_quad;
  logic [CORE_LATENCY-1:0]  r_tag_v;
  logic [ID_W-1:0]          r_tag_id [CORE_LATENCY];
  logic                     r_res_valid;
  logic [ID_W-1:0]          r_res_id;
  logic [DATA_WIDTH-1:0]    r_res_x;
  logic [DATA_WIDTH-1:0]    r_res_y;
  logic [CNT_W-1:0]         r_inflight;
  logic                     r_err;

  logic [NUM_REQ-1:0]       w_ready;
  logic [ID_W-1:0]          w_gnt_id;
  logic [ID_W-1:0]          w_cand;
  logic                     w_found;
  logic                     w_tag_v;
  logic [ID_W-1:0]          w_tag_id;

  // Returns (base + off) mod NUM_REQ. The caller guarantees that base + off < 2*NUM_REQ.
  function automatic logic [ID_W-1:0] f_wrap(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // The search starts at r_ptr and wraps. Gating with nreset keeps req_ready low in the reset cycle.
  always_comb begin
    w_ready  = '0;
    w_gnt_id = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    if (nreset && !bus.hold) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        w_cand = f_wrap(int'(r_ptr), i);
        if (!w_found && bus.req_valid[w_cand]) begin
          w_found          = 1'b1;
          w_gnt_id         = w_cand;
          w_ready[w_cand]  = 1'b1;
        end
      end
    end
  end

  // The last tag stage lines up with core_vld.
  assign w_tag_v  = r_tag_v[CORE_LATENCY-1];
  assign w_tag_id = r_tag_id[CORE_LATENCY-1];

  always_ff @(posedge clk) begin
    if (!nreset) begin
      r_ptr        <= '0;
      r_core_en    <= 1'b0;
      r_issue_id   <= '0;
      r_core_mode  <= 1'b0;
      r_core_x     <= '0;
      r_core_y     <= '0;
      r_core_angle <= '0;
      r_core_dir   <= '0;
      r_core_quad  <= '0;
      r_tag_v      <= '0;
      for (int k = 0; k < CORE_LATENCY; k++) r_tag_id[k] <= '0;
      r_res_valid  <= 1'b0;
      r_res_id     <= '0;
      r_res_x      <= '0;
      r_res_y      <= '0;
      r_inflight   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_core_en <= w_found;
      if (w_found) begin
        r_ptr        <= f_wrap(int'(w_gnt_id), 1);
        r_issue_id   <= w_gnt_id;
        r_core_mode  <= bus.req_mode[w_gnt_id];
        r_core_x     <= bus.req_x[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        r_core_y     <= bus.req_y[int'(w_gnt_id)*DATA_WIDTH +: DATA_WIDTH];
        r_core_angle <= bus.req_angle[int'(w_gnt_id)*ANGLE_WIDTH +: ANGLE_WIDTH];
        r_core_dir   <= bus.req_dir[int'(w_gnt_id)*CORDIC_STAGES +: CORDIC_STAGES];
        r_core_quad  <= bus.req_quad[int'(w_gnt_id)*2 +: 2];
      end

      r_tag_v     <= {r_tag_v[CORE_LATENCY-2:0], r_core_en};
      r_tag_id[0] <= r_issue_id;
      for (int k = 1; k < CORE_LATENCY; k++) r_tag_id[k] <= r_tag_id[k-1];

      // A core_vld without a valid tag sets err and emits no result.
      r_res_valid <= bus.core_vld & w_tag_v;
      if (bus.core_vld && w_tag_v) begin
        r_res_id <= w_tag_id;
        r_res_x  <= bus.core_xo;
        r_res_y  <= bus.core_yo;
      end
      if (bus.core_vld != w_tag_v) r_err <= 1'b1;

      case ({r_core_en, r_res_valid})
        2'b10:   r_inflight <= r_inflight + CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.core_en    = r_core_en;
  assign bus.core_mode  = r_core_mode;
  assign bus.core_x     = r_core_x;
  assign bus.core_y     = r_core_y;
  assign bus.core_angle = r_core_angle;
  assign bus.core_dir   = r_core_dir;
  assign bus.core_quad  = r_core_quad;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_x      = r_res_x;
  assign bus.res_y      = r_res_y;
  assign bus.inflight   = r_inflight;
  assign bus.err        = r_err;
  assign bus.idle       = (r_inflight == '0) && !r_core_en && (bus.req_valid == '0);
endmodule

// File: tb/tb_cordic_rot_sched.sv
// tb_cordic_rot_sched
//   Directed bench for cordic_rot_sched with default parameters.
//   The rotation core is replaced by an 18-deep delay line.
//   The delay line returns xo = x + angle and yo = y - angle.
//   This makes each result traceable to its operands.
module tb_cordic_rot_sched;
  localparam int L = 18;

  logic clk = 1'b0;
  logic nreset;
  logic inj;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_rot_sched_if bus ();

  cordic_rot_sched dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  // Stand-in rotation core, reset by the same nreset.
  logic [L-1:0] m_v;
  logic [15:0]  m_x [L];
  logic [15:0]  m_y [L];
  always @(posedge clk) begin
    if (!nreset) m_v <= '0;
    else begin
      m_v    <= {m_v[L-2:0], bus.core_en};
      m_x[0] <= bus.core_x + bus.core_angle;
      m_y[0] <= bus.core_y - bus.core_angle;
      for (int k = 1; k < L; k++) begin
        m_x[k] <= m_x[k-1];
        m_y[k] <= m_y[k-1];
      end
    end
  end
  assign bus.core_vld = m_v[L-1] | inj;
  assign bus.core_xo  = m_x[L-1];
  assign bus.core_yo  = m_y[L-1];

  typedef struct {
    int          id;
    logic [15:0] x;
    logic [15:0] y;
    int          c;
  } res_t;
  res_t rq[$];

  always @(negedge clk)
    if (bus.res_valid === 1'b1) rq.push_back('{int'(bus.res_id), bus.res_x, bus.res_y, cyc});

  function automatic res_t get_res(int k);
    res_t r;
    r = '{-1, 16'hxxxx, 16'hxxxx, -1};
    if (k < rq.size()) r = rq[k];
    return r;
  endfunction

  task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] q, input logic m);
    bus.req_x[i*16 +: 16]     = x;
    bus.req_y[i*16 +: 16]     = y;
    bus.req_angle[i*16 +: 16] = a;
    bus.req_dir[i*16 +: 16]   = d;
    bus.req_quad[i*2 +: 2]    = q;
    bus.req_mode[i]           = m;
  endtask

  task automatic pulse_reset();
    @(negedge clk); nreset = 1'b0;
    @(negedge clk); nreset = 1'b1;
  endtask

  task automatic wait_res(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (rq.size() < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    ok = (rq.size() >= target);
  endtask

  task automatic test_reset();
    bus.hold = 1'b0; bus.req_valid = '1; inj = 1'b0; nreset = 1'b0;
    bus.req_mode = '0; bus.req_x = '0; bus.req_y = '0; bus.req_angle = '0;
    bus.req_dir = '0; bus.req_quad = '0;
    @(posedge clk); @(negedge clk); #1;
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
    checks++; if (bus.core_en !== 1'b0 || bus.core_x !== 16'h0 || bus.core_angle !== 16'h0) begin errors++; $display("FAIL reset_core got en=%b x=%h a=%h exp 0", bus.core_en, bus.core_x, bus.core_angle); end
    checks++; if (bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 || bus.res_x !== 16'h0 || bus.res_y !== 16'h0) begin errors++; $display("FAIL reset_res got v=%b id=%0d x=%h y=%h exp 0", bus.res_valid, bus.res_id, bus.res_x, bus.res_y); end
    checks++; if (bus.inflight !== 5'd0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_status got inflight=%0d err=%b exp 0/0", bus.inflight, bus.err); end
    checks++; if (bus.idle !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got=%b exp=0", bus.idle); end
    bus.req_valid = '0; #1;
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", bus.idle); end
    @(negedge clk); nreset = 1'b1;
  endtask

  task automatic test_single();
    int t0, n0; bit ok; res_t r;
    @(negedge clk);
    set_ops(2, 16'h4000, 16'h0000, 16'h2000, 16'hA5A5, 2'd1, 1'b1);
    bus.req_valid = 4'b0100; #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", bus.req_ready); end
    t0 = cyc; n0 = rq.size();
    @(negedge clk); bus.req_valid = '0; #1;
    checks++; if (bus.core_en !== 1'b1) begin errors++; $display("FAIL single_core_en got=%b exp=1", bus.core_en); end
    checks++; if (bus.core_x !== 16'h4000 || bus.core_y !== 16'h0 || bus.core_angle !== 16'h2000 || bus.core_dir !== 16'hA5A5 || bus.core_quad !== 2'd1 || bus.core_mode !== 1'b1)
      begin errors++; $display("FAIL single_operands got x=%h y=%h a=%h d=%h q=%0d m=%b", bus.core_x, bus.core_y, bus.core_angle, bus.core_dir, bus.core_quad, bus.core_mode); end
    @(negedge clk); #1;
    checks++; if (bus.core_en !== 1'b0 || bus.inflight !== 5'd1) begin errors++; $display("FAIL single_issue_once got en=%b inflight=%0d exp 0/1", bus.core_en, bus.inflight); end
    wait_res(n0 + 1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got=%0d results exp=1", rq.size() - n0); end
    r = get_res(n0);
    checks++; if (r.c - t0 !== 20) begin errors++; $display("FAIL single_latency got=%0d exp=20", r.c - t0); end
    checks++; if (r.id !== 2 || r.x !== 16'h6000 || r.y !== 16'hE000) begin errors++; $display("FAIL single_result got id=%0d x=%h y=%h exp 2/6000/e000", r.id, r.x, r.y); end
    @(negedge clk); #1;
    checks++; if (bus.inflight !== 5'd0 || bus.idle !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL single_drain got inflight=%0d idle=%b err=%b", bus.inflight, bus.idle, bus.err); end
  endtask

  task automatic test_fairness();
    int n0, en_cnt, peak, n; res_t r; logic [15:0] ex;
    pulse_reset();
    for (int i = 0; i < 4; i++)
      set_ops(i, 16'(16'h1000 * (i + 1)), 16'(i * 3), 16'(16'h10 * i), 16'h0, 2'd0, 1'b0);
    bus.req_valid = '1; n0 = rq.size(); en_cnt = 0; peak = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++; if (bus.req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_grant_%0d got=%b exp=%b", k, bus.req_ready, 4'(1 << (k % 4))); end
      if (k > 0 && bus.core_en === 1'b1) en_cnt++;
      @(negedge clk);
    end
    bus.req_valid = '0; #1;
    if (bus.core_en === 1'b1) en_cnt++;
    checks++; if (en_cnt !== 12) begin errors++; $display("FAIL fair_back_to_back got=%0d exp=12", en_cnt); end
    n = 0;
    while (rq.size() < n0 + 12 && n < 60) begin
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      @(negedge clk); #1; n++;
    end
    checks++; if (rq.size() < n0 + 12) begin errors++; $display("FAIL fair_timeout got=%0d results exp=12", rq.size() - n0); end
    checks++; if (peak !== 12) begin errors++; $display("FAIL fair_peak_inflight got=%0d exp=12", peak); end
    for (int j = 0; j < 12; j++) begin
      r = get_res(n0 + j);
      ex = 16'(16'h1000 * ((j % 4) + 1) + 16'h10 * (j % 4));
      checks++; if (r.id !== (j % 4) || r.x !== ex || r.y !== 16'((j % 4) * 3 - 16'h10 * (j % 4)))
        begin errors++; $display("FAIL fair_result_%0d got id=%0d x=%h y=%h exp id=%0d x=%h", j, r.id, r.x, r.y, j % 4, ex); end
    end
  endtask

  task automatic test_hold();
    int n0; bit ok;
    @(negedge clk);
    bus.hold = 1'b1; bus.req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL hold_ready_%0d got=%b exp=0000", k, bus.req_ready); end
      @(negedge clk);
    end
    bus.hold = 1'b0; #1; n0 = rq.size();
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL hold_release_first got=%b exp=0010", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b1000; #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL hold_release_second got=%b exp=1000", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b1111; #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL hold_ptr_end got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
    wait_res(n0 + 2, 40, ok);
    checks++; if (!ok || get_res(n0).id !== 1 || get_res(n0 + 1).id !== 3)
      begin errors++; $display("FAIL hold_result_ids got=%0d,%0d exp=1,3", get_res(n0).id, get_res(n0 + 1).id); end
    @(negedge clk);
  endtask

  task automatic test_mismatch();
    int n0;
    @(negedge clk); n0 = rq.size();
    inj = 1'b1;
    @(negedge clk); inj = 1'b0; #1;
    checks++; if (bus.err !== 1'b1 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL mismatch_err got err=%b res_valid=%b exp 1/0", bus.err, bus.res_valid); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.err !== 1'b1 || rq.size() !== n0) begin errors++; $display("FAIL mismatch_sticky got err=%b results=%0d exp 1/0", bus.err, rq.size() - n0); end
    pulse_reset(); #1;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL mismatch_clear got=%b exp=0", bus.err); end
  endtask

  task automatic test_reset_midflight();
    int n0;
    for (int i = 0; i < 4; i++)
      set_ops(i, 16'(16'h0100 * (i + 1)), 16'h0, 16'h0, 16'h0, 2'd0, 1'b0);
    @(negedge clk); bus.req_valid = '1; n0 = rq.size();
    repeat (5) @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (bus.inflight !== 5'd5) begin errors++; $display("FAIL midflight_inflight got=%0d exp=5", bus.inflight); end
    nreset = 1'b0;
    @(negedge clk); nreset = 1'b1; #1;
    checks++; if (bus.inflight !== 5'd0 || bus.core_en !== 1'b0) begin errors++; $display("FAIL midflight_cleared got inflight=%0d en=%b exp 0/0", bus.inflight, bus.core_en); end
    repeat (30) @(negedge clk);
    #1;
    checks++; if (rq.size() !== n0 || bus.err !== 1'b0) begin errors++; $display("FAIL midflight_no_results got=%0d err=%b exp 0/0", rq.size() - n0, bus.err); end
    bus.req_valid = 4'b1000; #1;
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL midflight_sole3 got=%b exp=1000", bus.req_ready); end
    bus.req_valid = 4'b1111; #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL midflight_ptr0 got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_isolation();
    int n0; bit ok; res_t r0, r1;
    @(negedge clk);
    set_ops(0, 16'h1000, 16'h0111, 16'h0000, 16'h00FF, 2'd0, 1'b1);
    set_ops(1, 16'h7000, 16'h0222, 16'h4000, 16'hFF00, 2'd3, 1'b0);
    bus.req_valid = 4'b0011; #1; n0 = rq.size();
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL iso_grant0 got=%b exp=0001", bus.req_ready); end
    @(negedge clk); bus.req_valid = 4'b0010; #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL iso_grant1 got=%b exp=0010", bus.req_ready); end
    checks++; if (bus.core_x !== 16'h1000 || bus.core_y !== 16'h0111 || bus.core_angle !== 16'h0 || bus.core_dir !== 16'h00FF || bus.core_quad !== 2'd0 || bus.core_mode !== 1'b1)
      begin errors++; $display("FAIL iso_ops0 got x=%h y=%h a=%h d=%h q=%0d m=%b", bus.core_x, bus.core_y, bus.core_angle, bus.core_dir, bus.core_quad, bus.core_mode); end
    @(negedge clk); bus.req_valid = '0; #1;
    checks++; if (bus.core_x !== 16'h7000 || bus.core_y !== 16'h0222 || bus.core_angle !== 16'h4000 || bus.core_dir !== 16'hFF00 || bus.core_quad !== 2'd3 || bus.core_mode !== 1'b0)
      begin errors++; $display("FAIL iso_ops1 got x=%h y=%h a=%h d=%h q=%0d m=%b", bus.core_x, bus.core_y, bus.core_angle, bus.core_dir, bus.core_quad, bus.core_mode); end
    wait_res(n0 + 2, 40, ok);
    r0 = get_res(n0); r1 = get_res(n0 + 1);
    checks++; if (!ok || r0.id !== 0 || r0.x !== 16'h1000 || r0.y !== 16'h0111) begin errors++; $display("FAIL iso_res0 got id=%0d x=%h y=%h exp 0/1000/0111", r0.id, r0.x, r0.y); end
    checks++; if (r1.id !== 1 || r1.x !== 16'hB000 || r1.y !== 16'hC222) begin errors++; $display("FAIL iso_res1 got id=%0d x=%h y=%h exp 1/b000/c222", r1.id, r1.x, r1.y); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_hold();
    test_mismatch();
    test_reset_midflight();
    test_isolation();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
